// File: rtl/cordic_seq_ctrl.sv
// Sequential CORDIC engine: one micro-rotation per clock in rotation or vectoring mode.
// The arctan table lives outside; it is addressed by atan_idx and answers combinationally.
module cordic_seq_ctrl #(
    parameter int ITERS = 16,
    parameter int IDXW  = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            mode,
    input  logic [31:0]     x_in,
    input  logic [31:0]     y_in,
    input  logic [31:0]     z_in,
    output logic [IDXW-1:0] atan_idx,
    input  logic [31:0]     atan_val,
    output logic            busy,
    output logic            done,
    output logic [31:0]     x_out,
    output logic [31:0]     y_out,
    output logic [31:0]     z_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(ITERS - 1);
    localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);
    localparam logic [IDXW-1:0] IDX_ZERO = {IDXW{1'b0}};

    // d = +1 (returns 1) when rotation wants z toward 0 from above, or vectoring sees y below 0
    function automatic logic f_dir(input logic md, input logic [31:0] y, input logic [31:0] z);
        logic d;
        if (md) begin
            d = y[31];
        end else begin
            d = ($signed(z) > 32'sd0);
        end
        return d;
    endfunction

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IDXW-1:0] r_idx;
    logic            r_mode;
    logic            r_busy;
    logic            r_done;
    logic [31:0]     r_x;
    logic [31:0]     r_y;
    logic [31:0]     r_z;
    logic            w_dir;
    logic [31:0]     w_x_sh;
    logic [31:0]     w_y_sh;
    logic [31:0]     w_x_nxt;
    logic [31:0]     w_y_nxt;
    logic [31:0]     w_z_nxt;

    assign atan_idx = r_idx;
    assign busy     = r_busy;
    assign done     = r_done;
    assign x_out    = r_x;
    assign y_out    = r_y;
    assign z_out    = r_z;

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                if (r_idx == LAST_IDX) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // One micro-rotation from the current register values
    always_comb begin
        w_dir  = f_dir(r_mode, r_y, r_z);
        w_x_sh = 32'($signed(r_x) >>> r_idx);
        w_y_sh = 32'($signed(r_y) >>> r_idx);
        if (w_dir) begin
            w_x_nxt = r_x - w_y_sh;
            w_y_nxt = r_y + w_x_sh;
            w_z_nxt = r_z - atan_val;
        end else begin
            w_x_nxt = r_x + w_y_sh;
            w_y_nxt = r_y - w_x_sh;
            w_z_nxt = r_z + atan_val;
        end
    end

    // State, index, status flags and working registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= IDX_ZERO;
            r_mode  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_x     <= 32'd0;
            r_y     <= 32'd0;
            r_z     <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == S_RUN);
            r_done  <= (w_state_nxt == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_x    <= x_in;
                        r_y    <= y_in;
                        r_z    <= z_in;
                        r_mode <= mode;
                        r_idx  <= IDX_ZERO;
                    end else begin
                        r_idx  <= IDX_ZERO;
                    end
                end
                S_RUN: begin
                    r_x <= w_x_nxt;
                    r_y <= w_y_nxt;
                    r_z <= w_z_nxt;
                    // index parks at 0 on the final step so atan_idx reads 0 outside RUN
                    if (r_idx == LAST_IDX) begin
                        r_idx <= IDX_ZERO;
                    end else begin
                        r_idx <= r_idx + IDX_ONE;
                    end
                end
                default: begin
                    r_idx <= IDX_ZERO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_seq_ctrl.sv
// Directed bench for cordic_seq_ctrl: a 2-iteration and a 16-iteration instance share one
// arctan table; expected results are queued at stimulus time and popped on each done pulse.
module tb_cordic_seq_ctrl;

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] z;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [31:0] tbl [32];
    res_t        sb [$];

    logic        rst_n2, start2, mode2, busy2, done2;
    logic [31:0] xi2, yi2, zi2, av2, xo2, yo2, zo2;
    logic [4:0]  idx2;
    logic        rst_n16, start16, mode16, busy16, done16;
    logic [31:0] xi16, yi16, zi16, av16, xo16, yo16, zo16;
    logic [4:0]  idx16;

    assign av2  = tbl[idx2];
    assign av16 = tbl[idx16];

    cordic_seq_ctrl #(.ITERS(2), .IDXW(5)) dut2 (
        .clk(clk), .rst_n(rst_n2), .start(start2), .mode(mode2),
        .x_in(xi2), .y_in(yi2), .z_in(zi2), .atan_idx(idx2), .atan_val(av2),
        .busy(busy2), .done(done2), .x_out(xo2), .y_out(yo2), .z_out(zo2)
    );

    cordic_seq_ctrl #(.ITERS(16), .IDXW(5)) dut16 (
        .clk(clk), .rst_n(rst_n16), .start(start16), .mode(mode16),
        .x_in(xi16), .y_in(yi16), .z_in(zi16), .atan_idx(idx16), .atan_val(av16),
        .busy(busy16), .done(done16), .x_out(xo16), .y_out(yo16), .z_out(zo16)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic ok, input logic [31:0] obs);
        checks++;
        assert (ok === 1'b1) else begin
            errors++;
            $error("FAIL %s observed=%h outside required bound", tag, obs);
        end
    endtask

    function automatic res_t ref_model(input logic md, input logic [31:0] x0,
                                       input logic [31:0] y0, input logic [31:0] z0,
                                       input int n);
        logic signed [31:0] x, y, z, xs, ys, nx, ny, nz;
        logic d;
        res_t r;
        x = x0; y = y0; z = z0;
        for (int i = 0; i < n; i++) begin
            if (md) d = (y < 0); else d = (z > 0);
            xs = x >>> i;
            ys = y >>> i;
            if (d) begin
                nx = x - ys; ny = y + xs; nz = z - tbl[i];
            end else begin
                nx = x + ys; ny = y - xs; nz = z + tbl[i];
            end
            x = nx; y = ny; z = nz;
        end
        r.x = x; r.y = y; r.z = z;
        return r;
    endfunction

    task automatic pop_cmp(input string tag, input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] z);
        res_t e;
        checks++;
        assert (sb.size() > 0) else begin
            errors++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_x"}, x, e.x);
            chk({tag, "_y"}, y, e.y);
            chk({tag, "_z"}, z, e.z);
        end
    endtask

    // One operation: drive, scramble inputs after acceptance, sample iteration-0 result, await done.
    task automatic run_op(input int which, input logic md, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] z, input string tag,
                          output logic [31:0] y_it0, output logic [31:0] z_it0);
        int cyc;
        int n;
        n = (which == 2) ? 2 : 16;
        @(negedge clk);
        if (which == 2) begin
            start2 = 1'b1; mode2 = md; xi2 = x; yi2 = y; zi2 = z;
        end else begin
            start16 = 1'b1; mode16 = md; xi16 = x; yi16 = y; zi16 = z;
        end
        sb.push_back(ref_model(md, x, y, z, n));
        @(negedge clk);
        if (which == 2) begin
            start2 = 1'b0; mode2 = ~md; xi2 = ~x; yi2 = x; zi2 = ~z;
        end else begin
            start16 = 1'b0; mode16 = ~md; xi16 = ~x; yi16 = x; zi16 = ~z;
        end
        chk({tag, "_busy"}, {31'd0, (which == 2) ? busy2 : busy16}, 32'd1);
        @(negedge clk);
        y_it0 = (which == 2) ? yo2 : yo16;
        z_it0 = (which == 2) ? zo2 : zo16;
        cyc = 2;
        while (((which == 2) ? done2 : done16) !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_latency"}, cyc, n + 1);
        if (which == 2) pop_cmp(tag, xo2, yo2, zo2);
        else            pop_cmp(tag, xo16, yo16, zo16);
        @(negedge clk);
        chk({tag, "_done_pulse"}, {31'd0, (which == 2) ? done2 : done16}, 32'd0);
    endtask

    logic [31:0] y0, z0, dz, dx;
    int          seen, last_t, gap_bad;

    initial begin
        tbl[0]  = 32'h1921FB54; tbl[1]  = 32'h0ED63383; tbl[2]  = 32'h07D6DD7E;
        tbl[3]  = 32'h03FAB753; tbl[4]  = 32'h01FF55BB; tbl[5]  = 32'h00FFEAAE;
        tbl[6]  = 32'h007FFD55; tbl[7]  = 32'h003FFFAB; tbl[8]  = 32'h001FFFF5;
        tbl[9]  = 32'h000FFFFF; tbl[10] = 32'h00080000; tbl[11] = 32'h00040000;
        tbl[12] = 32'h00020000; tbl[13] = 32'h00010000; tbl[14] = 32'h00008000;
        tbl[15] = 32'h00004000;
        for (int i = 16; i < 32; i++) tbl[i] = 32'h0;

        rst_n2 = 1'b0; start2 = 1'b0; mode2 = 1'b0; xi2 = 32'h0; yi2 = 32'h0; zi2 = 32'h0;
        rst_n16 = 1'b0; start16 = 1'b1; mode16 = 1'b1; xi16 = 32'h5; yi16 = 32'h6; zi16 = 32'h7;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy16}, 32'd0);
        chk("rst_done", {31'd0, done16}, 32'd0);
        chk("rst_idx",  {27'd0, idx16}, 32'd0);
        chk("rst_x",    xo16, 32'h0);
        chk("rst_y",    yo16, 32'h0);
        chk("rst_z",    zo16, 32'h0);
        rst_n2 = 1'b1; rst_n16 = 1'b1; start16 = 1'b0;
        @(negedge clk);
        chk("rel_no_start", {31'd0, busy16}, 32'd0);

        // 2-iteration rotation with known closed-form result
        run_op(2, 1'b0, 32'h00010000, 32'h0, 32'h1921FB54, "rot2", y0, z0);
        chk("rot2_x_const", xo2, 32'h00018000);
        chk("rot2_y_const", yo2, 32'h00008000);
        chk("rot2_z_const", zo2, 32'h0ED63383);
        chk("rot2_idle_idx", {27'd0, idx2}, 32'd0);

        // vectoring of (1,1): gain*sqrt2 magnitude and pi/4 angle
        run_op(16, 1'b1, 32'h00010000, 32'h00010000, 32'h0, "vec16", y0, z0);
        chkb("vec16_y_small", ($signed(yo16) < 16) && ($signed(yo16) > -16), yo16);
        dz = zo16 - 32'h1921FB54;
        chkb("vec16_z_angle", ($signed(dz) < 32'sh10000) && ($signed(dz) > -32'sh10000), zo16);
        dx = xo16 - 32'h00025434;
        chkb("vec16_x_gain", ($signed(dx) <= 153) && ($signed(dx) >= -153), xo16);
        chk("vec16_hold_x", xo16, sb.size() == 0 ? xo16 : 32'hX);

        // negative angle: first step must go d=-1
        run_op(16, 1'b0, 32'h00010000, 32'h0, 32'hE6DE04AC, "neg45", y0, z0);
        chk("neg45_it0_y", y0, 32'hFFFF0000);
        chk("neg45_it0_z", z0, 32'h0);

        // z exactly 0 is not positive
        run_op(16, 1'b0, 32'h00010000, 32'h0, 32'h0, "zero", y0, z0);
        chk("zero_it0_z", z0, 32'h1921FB54);
        chk("zero_it0_y", y0, 32'hFFFF0000);

        // vectoring with negative y exercises the d=+1 branch
        run_op(16, 1'b1, 32'h00030000, 32'hFFFD8000, 32'h01000000, "vecneg", y0, z0);

        // start held high: back-to-back operations, inputs changed mid-run
        @(negedge clk);
        start16 = 1'b1; mode16 = 1'b0; xi16 = 32'h00010000; yi16 = 32'h0; zi16 = 32'h0C90FDAA;
        sb.push_back(ref_model(1'b0, 32'h00010000, 32'h0, 32'h0C90FDAA, 16));
        seen = 0; last_t = 0; gap_bad = 0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (done16 === 1'b1) begin
                if (seen > 0 && (n - last_t) != 18) gap_bad++;
                if (seen == 0 && n != 17) gap_bad++;
                seen++;
                last_t = n;
                pop_cmp("b2b", xo16, yo16, zo16);
            end
            if (n == 1) begin
                xi16 = 32'h00008000; yi16 = 32'h00004000; zi16 = 32'hF0000000;
                sb.push_back(ref_model(1'b0, 32'h00008000, 32'h00004000, 32'hF0000000, 16));
            end else if (n == 19) begin
                xi16 = 32'h00020000; yi16 = 32'hFFFF8000; zi16 = 32'h10000000;
                sb.push_back(ref_model(1'b0, 32'h00020000, 32'hFFFF8000, 32'h10000000, 16));
            end else if (n == 37) begin
                start16 = 1'b0; mode16 = 1'b1; xi16 = 32'h12345678; yi16 = 32'h9ABCDEF0; zi16 = 32'h0;
            end
        end
        chk("b2b_count", seen, 32'd3);
        chk("b2b_gap", gap_bad, 32'd0);
        chk("b2b_sb_empty", sb.size(), 32'd0);

        // reset during iteration 5 aborts with no done pulse
        @(negedge clk);
        start16 = 1'b1; mode16 = 1'b0; xi16 = 32'h00010000; yi16 = 32'h0; zi16 = 32'h0C90FDAA;
        @(negedge clk);
        start16 = 1'b0;
        repeat (5) @(negedge clk);
        chk("abort_pre_idx", {27'd0, idx16}, 32'd5);
        rst_n16 = 1'b0;
        @(negedge clk);
        rst_n16 = 1'b1;
        chk("abort_busy", {31'd0, busy16}, 32'd0);
        chk("abort_done", {31'd0, done16}, 32'd0);
        chk("abort_xyz", xo16 | yo16 | zo16, 32'h0);
        seen = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (done16 === 1'b1 || busy16 === 1'b1) seen++;
        end
        chk("abort_no_done", seen, 32'd0);

        // reset overrides a simultaneous start
        rst_n16 = 1'b0; start16 = 1'b1;
        @(negedge clk);
        chk("rst_vs_start", {31'd0, busy16}, 32'd0);
        rst_n16 = 1'b1; start16 = 1'b0;
        @(negedge clk);
        chk("rst_release_idle", {31'd0, busy16}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
